// File: rtl/oam_dma.sv
// OAM DMA engine: on a write to the DMA source register, copies LEN bytes from
// page {src_hi, 8'h00} to DST_BASE through a one-read/one-write memory port.
// Read data is captured at the end of each byte slot. It is written out in the
// first cycle of the next slot, or in the DRAIN cycle for the last byte.
// Optional feature macro: OAM_DMA_ECHO_MIRROR_EN. When it is defined, source
// pages E0-FF read through the echo mirror at C0-DF.
module oam_dma #(
    parameter int unsigned LEN             = 160,
    parameter logic [15:0] DST_BASE        = 16'hFE00,
    parameter int unsigned START_DELAY     = 1,
    parameter int unsigned CYCLES_PER_BYTE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wen,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  src_hi,
    output logic        busy,
    output logic [15:0] mem_r_addr,
    input  logic [7:0]  mem_r_data,
    output logic        mem_wen,
    output logic [15:0] mem_w_addr,
    output logic [7:0]  mem_w_data
);

    typedef enum logic [1:0] {IDLE, DELAY, XFER, DRAIN} state_t;

    localparam logic [7:0] LAST_IDX  = 8'(LEN - 1);
    localparam logic [3:0] DLY_LAST  = 4'((START_DELAY == 0) ? 0 : START_DELAY - 1);
    localparam logic [2:0] SLOT_LAST = 3'(CYCLES_PER_BYTE - 1);
    // A zero start delay skips DELAY entirely, on the first trigger and on restarts.
    localparam state_t     START_ST  = (START_DELAY == 0) ? XFER : DELAY;

    state_t     state, state_nx;
    logic [3:0] dly_cnt;
    logic [2:0] slot_cnt;
    logic [7:0] rd_idx, widx_q, wdat_q;
    logic       wvalid_q;
    logic [7:0] rd_page;
    logic       slot_last, wr_fire;

`ifdef OAM_DMA_ECHO_MIRROR_EN
    assign rd_page = (src_hi >= 8'hE0) ? src_hi - 8'h20 : src_hi;
`else
    assign rd_page = src_hi;
`endif

    assign slot_last = (slot_cnt == SLOT_LAST);
    // The pending byte goes out at the start of the next slot, or in DRAIN.
    assign wr_fire   = wvalid_q && (((state == XFER) && (slot_cnt == 3'd0)) || (state == DRAIN));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and bus outputs. All outputs depend on registered state only.
    always_comb begin
        state_nx   = state;
        busy       = (state != IDLE);
        mem_r_addr = 16'h0000;
        mem_wen    = wr_fire;
        mem_w_addr = 16'h0000;
        mem_w_data = 8'h00;
        if (state == XFER) mem_r_addr = {rd_page, rd_idx};
        if (wr_fire) begin
            mem_w_addr = DST_BASE + {8'h00, widx_q};
            mem_w_data = wdat_q;
        end
        case (state)
            IDLE:  if (reg_wen) state_nx = START_ST;
            DELAY: if (reg_wen) state_nx = START_ST;
                   else if (dly_cnt == DLY_LAST) state_nx = XFER;
            XFER:  if (reg_wen) state_nx = START_ST;
                   else if (slot_last && (rd_idx == LAST_IDX)) state_nx = DRAIN;
            DRAIN: state_nx = reg_wen ? START_ST : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counters, source latch and the one-deep write buffer. A trigger overrides
    // everything else, so a restart discards any byte captured in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_hi   <= 8'h00;
            dly_cnt  <= 4'd0;
            slot_cnt <= 3'd0;
            rd_idx   <= 8'h00;
            widx_q   <= 8'h00;
            wdat_q   <= 8'h00;
            wvalid_q <= 1'b0;
        end else begin
            if (wr_fire) wvalid_q <= 1'b0;
            case (state)
                DELAY: dly_cnt <= dly_cnt + 4'd1;
                XFER: begin
                    if (slot_last) begin
                        slot_cnt <= 3'd0;
                        wdat_q   <= mem_r_data;
                        widx_q   <= rd_idx;
                        wvalid_q <= 1'b1;
                        rd_idx   <= rd_idx + 8'd1;
                    end else begin
                        slot_cnt <= slot_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
            if (reg_wen) begin
                src_hi   <= reg_wdata;
                wvalid_q <= 1'b0;
                rd_idx   <= 8'h00;
                slot_cnt <= 3'd0;
                dly_cnt  <= 4'd0;
            end
        end
    end

endmodule
